sha256_req_arbiter: RTL

Shares one `sha_256` hashing core between two requesters. Each requester submits a 24-bit message. The arbiter grants one requester at a time, loads that message onto the core's `data_in`, and restarts the core with a one-cycle reset pulse on its `rst`. It then waits a fixed core latency, captures the 256-bit `digest` and returns it to the granted requester with a done pulse. It sits between the requester logic and the `sha_256` instance and is the only block that drives the core's `rst` and `data_in`.

---
 rtl/sha256_req_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sha256_req_arbiter.sv
// ---------------------------------------------------------------------------
// sha256_req_arbiter
//
// Shares a single sha_256 core between two requesters. A granted message is
// latched onto the core input and the core is restarted with a one-cycle
// reset pulse. After CORE_LAT cycles the core digest is captured and returned
// to the owner with a one-cycle done pulse.
//
// Configuration macro:
//   SHA_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                          undefined -> round-robin using a one-bit pointer
//
// Parameters:
//   CORE_LAT     cycles from the core reset pulse to a valid core_digest
//                (1..255)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req0/req1    request lines, held until the matching grant
//   data0/data1  24-bit messages, stable while the request is high
//   gnt0/gnt1    one-cycle grant pulses (LOAD cycle)
//   done0/done1  one-cycle completion pulses to the owner
//   digest_out   last captured digest, cleared by reset
//   busy         high in every state except IDLE
//   core_rst     reset pulse to the sha_256 core
//   core_data    message driven onto the sha_256 core
//   core_digest  digest returned by the sha_256 core
// ---------------------------------------------------------------------------
module sha256_req_arbiter #(
  parameter int CORE_LAT = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [23:0]  data0,
  input  logic         req1,
  input  logic [23:0]  data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [255:0] digest_out,
  output logic         busy,
  output logic         core_rst,
  output logic [23:0]  core_data,
  input  logic [255:0] core_digest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter value on the last RUN cycle; RUN spans CORE_LAT cycles.
  localparam logic [7:0] LAST_CNT = 8'(CORE_LAT - 1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        owner_r;      // requester that owns the running job
`ifndef SHA_ARB_FIXED_PRIO_EN
  logic        last_r;       // most recent grant, used to break ties
`endif

  logic        any_req_s;
  logic        win_s;        // 0 = requester 0, 1 = requester 1
  logic [23:0] win_data_s;

  // Arbitration: pick the winner among the active requests.
  always_comb begin
    any_req_s  = req0 | req1;
    win_s      = 1'b0;
    win_data_s = data0;
`ifdef SHA_ARB_FIXED_PRIO_EN
    if (req0) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`else
    // On a tie the requester that did not win last time goes first.
    if (req0 && req1) begin
      win_s = ~last_r;
    end else if (req0) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
`endif
    if (win_s) begin
      win_data_s = data1;
    end else begin
      win_data_s = data0;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      owner_r    <= 1'b0;
`ifndef SHA_ARB_FIXED_PRIO_EN
      last_r     <= 1'b1;
`endif
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      digest_out <= 256'd0;
      core_data  <= 24'd0;
      // Held high through reset so the core also starts from a clean state.
      core_rst   <= 1'b1;
    end else begin
      // Pulse outputs return low unless a state below raises them.
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      core_rst <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt0      <= ~win_s;
            gnt1      <= win_s;
            core_data <= win_data_s;
            core_rst  <= 1'b1;
            owner_r   <= win_s;
`ifndef SHA_ARB_FIXED_PRIO_EN
            last_r    <= win_s;
`endif
            busy      <= 1'b1;
            state_r   <= LOAD;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        LOAD: begin
          cnt_r   <= 8'd0;
          busy    <= 1'b1;
          state_r <= RUN;
        end
        RUN: begin
          busy <= 1'b1;
          if (cnt_r == LAST_CNT) begin
            digest_out <= core_digest;
            done0      <= ~owner_r;
            done1      <= owner_r;
            state_r    <= DONE;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
